// File: rtl/shift_subtractor.sv
// rtl/shift_subtractor.sv - pipelined W-bit unsigned subtractor from N-bit slices with registered borrows
// Inputs are skewed per slice and outputs deskewed, so results leave word-aligned after S cycles.
module shift_subtractor #(
  parameter int W = 16,
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  input  logic [W-1:0] in_a,
  input  logic [W-1:0] in_b,
  output logic         out_valid,
  output logic [W-1:0] out_diff,
  output logic         out_borrow
);

  localparam int S = W / N;

  logic [W-1:0] w_diff_aligned;

  genvar k;
  generate
    for (k = 0; k < S; k++) begin : g_slice
      logic [N-1:0] w_a;
      logic [N-1:0] w_b;
      logic         w_v;
      logic         w_bin;
      logic [N:0]   w_res;
      logic [N-1:0] w_dout;
      logic [N-1:0] r_diff;
      logic         r_bor;
      logic         r_v;

      if (k == 0) begin : g_live
        assign w_a   = in_a[N-1:0];
        assign w_b   = in_b[N-1:0];
        assign w_v   = in_valid;
        assign w_bin = 1'b0;
      end else begin : g_skew
        // Chunk k and its valid bit are delayed k cycles to meet the borrow from slice k-1.
        logic [N-1:0] r_a_sk [k];
        logic [N-1:0] r_b_sk [k];
        logic         r_v_sk [k];

        always_ff @(posedge clk or posedge rst) begin
          if (rst) begin
            for (int j = 0; j < k; j++) begin
              r_a_sk[j] <= '0;
              r_b_sk[j] <= '0;
              r_v_sk[j] <= 1'b0;
            end
          end else begin
            r_a_sk[0] <= in_a[k*N +: N];
            r_b_sk[0] <= in_b[k*N +: N];
            r_v_sk[0] <= in_valid;
            for (int j = 1; j < k; j++) begin
              r_a_sk[j] <= r_a_sk[j-1];
              r_b_sk[j] <= r_b_sk[j-1];
              r_v_sk[j] <= r_v_sk[j-1];
            end
          end
        end

        assign w_a   = r_a_sk[k-1];
        assign w_b   = r_b_sk[k-1];
        assign w_v   = r_v_sk[k-1];
        assign w_bin = g_slice[k-1].r_bor;
      end

      assign w_res = {1'b0, w_a} - {1'b0, w_b} - {{N{1'b0}}, w_bin};

      // Borrow is forced low on bubbles so an idle stage never leaks into the next slice.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_diff <= '0;
          r_bor  <= 1'b0;
          r_v    <= 1'b0;
        end else begin
          r_diff <= w_res[N-1:0];
          r_bor  <= w_v & w_res[N];
          r_v    <= w_v;
        end
      end

      if (k < S - 1) begin : g_deskew
        logic [N-1:0] r_dsk [S-1-k];

        always_ff @(posedge clk or posedge rst) begin
          if (rst) begin
            for (int j = 0; j < S - 1 - k; j++) begin
              r_dsk[j] <= '0;
            end
          end else begin
            r_dsk[0] <= r_diff;
            for (int j = 1; j < S - 1 - k; j++) begin
              r_dsk[j] <= r_dsk[j-1];
            end
          end
        end

        assign w_dout = r_dsk[S-2-k];
      end else begin : g_last
        assign w_dout = r_diff;
      end

      assign w_diff_aligned[k*N +: N] = w_dout;
    end
  endgenerate

  assign out_diff   = w_diff_aligned;
  assign out_borrow = g_slice[S-1].r_bor;
  assign out_valid  = g_slice[S-1].r_v;

endmodule

// File: tb/tb_shift_subtractor.sv
// tb/tb_shift_subtractor.sv - directed and scoreboard checks of shift_subtractor at W=16/N=4 and W=8/N=8
module tb_shift_subtractor;

  localparam int S = 4;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic [15:0] in_a;
  logic [15:0] in_b;
  logic        out_valid;
  logic [15:0] out_diff;
  logic        out_borrow;

  logic        s1_valid;
  logic [7:0]  s1_a;
  logic [7:0]  s1_b;
  logic        s1_ovalid;
  logic [7:0]  s1_diff;
  logic        s1_borrow;

  int n_tests;
  int n_fail;

  shift_subtractor #(.W(16), .N(4)) u_dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_a      (in_a),
    .in_b      (in_b),
    .out_valid (out_valid),
    .out_diff  (out_diff),
    .out_borrow(out_borrow)
  );

  shift_subtractor #(.W(8), .N(8)) u_dut_s1 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (s1_valid),
    .in_a      (s1_a),
    .in_b      (s1_b),
    .out_valid (s1_ovalid),
    .out_diff  (s1_diff),
    .out_borrow(s1_borrow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [15:0] a, input logic [15:0] b);
    in_valid = v;
    in_a     = a;
    in_b     = b;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_out(input string tag, input logic v, input logic [15:0] d, input logic bor);
    check({tag, "_valid"}, 32'(out_valid), 32'(v));
    if (v) begin
      check({tag, "_diff"}, 32'(out_diff), 32'(d));
      check({tag, "_borrow"}, 32'(out_borrow), 32'(bor));
    end
  endtask

  task automatic single(input string tag, input logic [15:0] a, input logic [15:0] b,
                        input logic [15:0] d, input logic bor);
    drive(1'b1, a, b);
    tick();
    drive(1'b0, 16'h0, 16'h0);
    repeat (S - 2) tick();
    check({tag, "_early"}, 32'(out_valid), 32'd0);
    tick();
    check_out(tag, 1'b1, d, bor);
    tick();
    check({tag, "_onecycle"}, 32'(out_valid), 32'd0);
  endtask

  typedef struct {
    logic        v;
    logic [15:0] a;
    logic [15:0] b;
  } op_t;

  op_t hist[$];
  int  pat[6];

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst = 1'b0;
    drive(1'b0, 16'h0, 16'h0);
    s1_valid = 1'b0;
    s1_a = 8'h0;
    s1_b = 8'h0;
    #1 rst = 1'b1;
    #1;
    check("reset_valid", 32'(out_valid), 32'd0);
    check("reset_diff", 32'(out_diff), 32'd0);
    check("reset_borrow", 32'(out_borrow), 32'd0);
    check("reset_s1_valid", 32'(s1_ovalid), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    single("ripple", 16'h1000, 16'h0001, 16'h0FFF, 1'b0);
    single("underflow", 16'h0000, 16'h0001, 16'hFFFF, 1'b1);
    single("equal", 16'h1234, 16'h1234, 16'h0000, 1'b0);
    single("max_b", 16'h0000, 16'hFFFF, 16'h0001, 1'b1);

    drive(1'b1, 16'h0000, 16'h0001);
    tick();
    drive(1'b1, 16'h0010, 16'h0000);
    tick();
    drive(1'b1, 16'hFFFF, 16'hFFFF);
    tick();
    drive(1'b0, 16'h0, 16'h0);
    tick();
    check_out("b2b_0", 1'b1, 16'hFFFF, 1'b1);
    tick();
    check_out("b2b_1", 1'b1, 16'h0010, 1'b0);
    tick();
    check_out("b2b_2", 1'b1, 16'h0000, 1'b0);
    tick();
    check("b2b_end", 32'(out_valid), 32'd0);

    pat = '{1, 0, 0, 1, 0, 1};
    for (int i = 0; i < 10; i++) begin
      if (i < 6 && pat[i] != 0) drive(1'b1, 16'h8000, 16'h0001);
      else drive(1'b0, 16'h0, 16'h0);
      tick();
      if (i >= S - 1) begin
        if (i - (S - 1) < 6 && pat[i-(S-1)] != 0) check_out($sformatf("bubble_%0d", i), 1'b1, 16'h7FFF, 1'b0);
        else check_out($sformatf("bubble_%0d", i), 1'b0, 16'h0, 1'b0);
      end
    end

    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 16'h8000, 16'h0001);
      tick();
    end
    drive(1'b0, 16'h0, 16'h0);
    check_out("prerst", 1'b1, 16'h7FFF, 1'b0);
    #2 rst = 1'b1;
    #1;
    check("midrst_valid", 32'(out_valid), 32'd0);
    check("midrst_diff", 32'(out_diff), 32'd0);
    check("midrst_borrow", 32'(out_borrow), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    check("inrst_valid", 32'(out_valid), 32'd0);
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      check($sformatf("stale_%0d", i), 32'(out_valid), 32'd0);
    end
    single("postrst", 16'h0005, 16'h0003, 16'h0002, 1'b0);

    s1_valid = 1'b1; s1_a = 8'h05; s1_b = 8'h07;
    tick();
    check("s1_v0", 32'(s1_ovalid), 32'd1);
    check("s1_d0", 32'(s1_diff), 32'h0FE);
    check("s1_b0", 32'(s1_borrow), 32'd1);
    s1_a = 8'h80; s1_b = 8'h80;
    tick();
    check("s1_v1", 32'(s1_ovalid), 32'd1);
    check("s1_d1", 32'(s1_diff), 32'h000);
    check("s1_b1", 32'(s1_borrow), 32'd0);
    s1_valid = 1'b0; s1_a = 8'h0; s1_b = 8'h0;
    tick();
    check("s1_v2", 32'(s1_ovalid), 32'd0);

    repeat (S) tick();
    hist.delete();
    for (int i = 0; i < 400; i++) begin
      op_t o;
      o.v = ($urandom_range(0, 3) != 0);
      o.a = 16'($urandom);
      o.b = 16'($urandom);
      if (i % 37 == 0) o.b = o.a;
      drive(o.v, o.a, o.b);
      tick();
      hist.push_front(o);
      if (hist.size() >= S) begin
        op_t e;
        e = hist[S-1];
        check_out($sformatf("rand_%0d", i), e.v, 16'(e.a - e.b), (e.a < e.b));
      end
    end
    drive(1'b0, 16'h0, 16'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
